// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-width encoding,
// FSM state type and the alignment helper.
package dmem_pkg;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd2;
    localparam logic [1:0] WIDTH_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Byte accesses can never be misaligned; wider ones need their low address bits clear.
    function automatic logic isMisaligned(input logic [1:0] width, input logic [2:0] addrLow);
        logic mis;
        mis = 1'b0;
        case (width)
            WIDTH_H: mis = addrLow[0];
            WIDTH_W: mis = |addrLow[1:0];
            WIDTH_D: mis = |addrLow;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the two-port data-memory arbiter; requesters use
// the master modport, the arbiter uses the slave modport.
interface dmem_arbiter_if #(
    parameter int REG_WIDTH = 64
);

    logic                 r0_valid;
    logic                 r0_ready;
    logic                 r0_write;
    logic                 r0_sign;
    logic [1:0]           r0_width;
    logic [REG_WIDTH-1:0] r0_addr;
    logic [REG_WIDTH-1:0] r0_wdata;
    logic                 r0_resp_valid;
    logic                 r0_resp_err;
    logic [REG_WIDTH-1:0] r0_rdata;

    logic                 r1_valid;
    logic                 r1_ready;
    logic                 r1_write;
    logic                 r1_sign;
    logic [1:0]           r1_width;
    logic [REG_WIDTH-1:0] r1_addr;
    logic [REG_WIDTH-1:0] r1_wdata;
    logic                 r1_resp_valid;
    logic                 r1_resp_err;
    logic [REG_WIDTH-1:0] r1_rdata;

    modport master (
        output r0_valid, r0_write, r0_sign, r0_width, r0_addr, r0_wdata,
        input  r0_ready, r0_resp_valid, r0_resp_err, r0_rdata,
        output r1_valid, r1_write, r1_sign, r1_width, r1_addr, r1_wdata,
        input  r1_ready, r1_resp_valid, r1_resp_err, r1_rdata
    );

    modport slave (
        input  r0_valid, r0_write, r0_sign, r0_width, r0_addr, r0_wdata,
        output r0_ready, r0_resp_valid, r0_resp_err, r0_rdata,
        input  r1_valid, r1_write, r1_sign, r1_width, r1_addr, r1_wdata,
        output r1_ready, r1_resp_valid, r1_resp_err, r1_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// requester that was not granted last time.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_lastGrant,
    output logic [1:0] o_grant
);

    assign o_grant[0] = i_req[0] & (~i_req[1] | i_lastGrant);
    assign o_grant[1] = i_req[1] & (~i_req[0] | ~i_lastGrant);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one registered-read data memory between two requesters: arbitrate in
// IDLE, drive the memory for one ISSUE cycle, return the result in RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        bus,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemSign,
    output logic [1:0]           MemWidth,
    output logic [REG_WIDTH-1:0] full_addr,
    output logic [REG_WIDTH-1:0] wdata,
    input  logic [REG_WIDTH-1:0] rdata
);

    state_t                 r_state;
    logic                   r_lastGrant;
    logic                   r_id;
    logic                   r_write;
    logic                   r_sign;
    logic                   r_mis;
    logic [1:0]             r_width;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [REG_WIDTH-1:0]   r_wdata;

    logic [1:0]             w_req;
    logic [1:0]             w_grant;
    logic                   w_hs;
    logic                   w_gid;
    logic                   w_selWrite;
    logic                   w_selSign;
    logic [1:0]             w_selWidth;
    logic [ADDR_WIDTH-1:0]  w_selAddr;
    logic [REG_WIDTH-1:0]   w_selWdata;
    logic                   w_selMis;
    logic                   w_issue;
    logic                   w_resp;
    logic                   w_loadOk;

    // Requests only compete while idle and out of reset, so ready stays low otherwise.
    assign w_req = {bus.r1_valid, bus.r0_valid} & {2{(r_state == IDLE) && !rst}};

    rr_arb2 u_arb (
        .i_req       (w_req),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant)
    );

    assign bus.r0_ready = w_grant[0];
    assign bus.r1_ready = w_grant[1];
    assign w_hs         = |w_grant;
    assign w_gid        = w_grant[1];

    assign w_selWrite = w_gid ? bus.r1_write : bus.r0_write;
    assign w_selSign  = w_gid ? bus.r1_sign  : bus.r0_sign;
    assign w_selWidth = w_gid ? bus.r1_width : bus.r0_width;
    assign w_selAddr  = w_gid ? bus.r1_addr[ADDR_WIDTH-1:0] : bus.r0_addr[ADDR_WIDTH-1:0];
    assign w_selWdata = w_gid ? bus.r1_wdata : bus.r0_wdata;
    assign w_selMis   = isMisaligned(w_selWidth, w_selAddr[2:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_id        <= 1'b0;
            r_write     <= 1'b0;
            r_sign      <= 1'b0;
            r_mis       <= 1'b0;
            r_width     <= WIDTH_B;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_id        <= w_gid;
                        r_lastGrant <= w_gid;
                        r_write     <= w_selWrite;
                        r_sign      <= w_selSign;
                        r_width     <= w_selWidth;
                        r_addr      <= w_selAddr;
                        r_wdata     <= w_selWdata;
                        r_mis       <= w_selMis;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // A misaligned access still occupies its slot but never touches memory.
    assign w_issue   = (r_state == ISSUE);
    assign MemRead   = w_issue && !rst && !r_mis && !r_write;
    assign MemWrite  = w_issue && !rst && !r_mis &&  r_write;
    assign MemSign   = w_issue && r_sign;
    assign MemWidth  = w_issue ? r_width : WIDTH_B;
    assign full_addr = w_issue ? REG_WIDTH'(r_addr) : '0;
    assign wdata     = w_issue ? r_wdata : '0;

    // Reset during RESP suppresses the completion pulse of the aborted transaction.
    assign w_resp   = (r_state == RESP) && !rst;
    assign w_loadOk = w_resp && !r_mis && !r_write;

    assign bus.r0_resp_valid = w_resp && !r_id;
    assign bus.r0_resp_err   = w_resp && !r_id && r_mis;
    assign bus.r0_rdata      = (w_loadOk && !r_id) ? rdata : '0;
    assign bus.r1_resp_valid = w_resp && r_id;
    assign bus.r1_resp_err   = w_resp && r_id && r_mis;
    assign bus.r1_rdata      = (w_loadOk && r_id) ? rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, meaning data and address width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning effective memory address bits checked for alignment.
REQ-003 SHALL have port clk  in  1  rising-edge clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have, for each requester n in {0,1}: rn_valid in 1 request present; rn_ready out 1 request accepted this cycle.
REQ-006 SHALL have, per requester: rn_write in 1 store; rn_sign in 1 unsigned-load flag (1 = zero-extend); rn_width in 2 (0 byte, 1 half, 2 word, 3 double).
REQ-007 SHALL have, per requester: rn_addr in REG_WIDTH byte address; rn_wdata in REG_WIDTH store data.
REQ-008 SHALL have, per requester: rn_resp_valid out 1 completion pulse; rn_resp_err out 1 misaligned; rn_rdata out REG_WIDTH load data.
REQ-009 SHALL have memory-side outputs MemRead, MemWrite, MemSign (1), MemWidth (2), full_addr, wdata (REG_WIDTH), and input rdata (REG_WIDTH) from a memory that registers reads on clk.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, RESP; ISSUE and RESP each last exactly one cycle.
REQ-011 In IDLE, SHALL assert rn_ready combinationally for exactly one requester chosen by arbitration when any rn_valid is high; handshake = rn_valid & rn_ready.
REQ-012 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last; after reset, r0 has priority.
REQ-013 On handshake, SHALL latch the granted request (write, sign, width, addr, wdata, id) and update last-grant; IDLE -> ISSUE.
REQ-014 In ISSUE, SHALL drive MemRead = ~write, MemWrite = write, plus MemSign, MemWidth, full_addr, wdata from the latch; ISSUE -> RESP.
REQ-015 In RESP, SHALL pulse rn_resp_valid for the latched id for one cycle, rn_rdata = rdata for loads (0 for stores); RESP -> IDLE.
REQ-016 Outside ISSUE, MemRead and MemWrite SHALL be 0; full_addr, wdata, MemWidth, MemSign SHALL be 0.
REQ-017 Misaligned request (addr[width-1:0] nonzero, i.e., half bit0, word bits1:0, double bits2:0) SHALL still be accepted but in ISSUE drive MemRead = MemWrite = 0, and in RESP pulse rn_resp_valid with rn_resp_err = 1, rn_rdata = 0.
REQ-018 Byte accesses SHALL never be misaligned.
REQ-019 Request inputs SHALL be ignored outside IDLE; rn_ready SHALL be 0 in ISSUE and RESP; throughput is one transaction per 3 cycles.
REQ-020 Latency from handshake edge to rn_resp_valid SHALL be exactly 2 cycles.
REQ-021 rn_rdata and rn_resp_err SHALL be held at 0 when rn_resp_valid is low.

Reset
REQ-022 On rst high at a clk edge: state = IDLE, last-grant = r1 (so r0 wins next tie), latch cleared, all outputs 0.
REQ-023 Reset mid-ISSUE or mid-RESP SHALL abort the transaction with no rn_resp_valid pulse; a store reset in ISSUE still reaches memory that cycle only if rst sampled low at that edge.
REQ-024 rn_ready SHALL be 0 while rst is high.

Structure
REQ-025 Package dmem_pkg SHALL hold the width encoding constants (WIDTH_B/H/W/D) and the state enum type.
REQ-026 Arbitration SHALL live in sub-module rr_arb2 (two requests, last-grant input, one-hot grant output); alignment check and FSM stay in dmem_arbiter.

Verification
REQ-027 r0 load double addr 0x10 after r0 store 0x1122334455667788 to 0x10 -> r0_resp_valid 2 cycles after handshake, r0_rdata = 0x1122334455667788, err 0.
REQ-028 r0 and r1 valid together after reset -> grants r0, r1, r0, r1 in order, each 3 cycles apart.
REQ-029 r1 load word signed from addr 0x20 holding 0x80000000 -> r1_rdata = 0xFFFFFFFF80000000; with r1_sign = 1 -> 0x0000000080000000.
REQ-030 r0 store half to addr 0x21 -> MemWrite never asserted, r0_resp_err = 1, memory at 0x20/0x21 unchanged on readback.
REQ-031 rst asserted in RESP cycle of a load -> no resp_valid, state IDLE next cycle, next request served normally.
REQ-032 r1 valid held during r0 transaction -> r1_ready stays 0 until IDLE, then granted; no request lost or duplicated.
